// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect push-buttons and slide switches; collect edges in a sticky event word.
// Build option: define INPUT_COND_RELEASE_EN to generate key_release pulses and event_word[3:2].
`timescale 1ns/1ps
module input_conditioner #(
  parameter int N_KEY           = 2,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_KEY-1:0]  key_raw,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_KEY-1:0]  key_level,
  output logic [N_SW-1:0]   sw_level,
  output logic [N_KEY-1:0]  key_press,
  output logic [N_KEY-1:0]  key_release,
  output logic [N_SW-1:0]   sw_change,
  output logic [15:0]       event_word,
  output logic              event_valid,
  input  logic              event_ack
);

  localparam int NI = N_KEY + N_SW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Keys occupy the low bits; inverting them up front makes every input active-high.
  logic [NI-1:0] raw;
  logic [NI-1:0] sync1, sync2;
  logic [NI-1:0] stable, stable_d;
  logic [CW-1:0] cnt [NI];

  assign raw = {sw_raw, ~key_raw};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      // NOTE: the counters are reset too, so a partially counted debounce cannot survive reset.
      for (int i = 0; i < NI; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < NI; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign key_level = stable[N_KEY-1:0];
  assign sw_level  = stable[NI-1:N_KEY];

  logic [N_KEY-1:0] key_rise;
  logic [N_SW-1:0]  sw_diff;

  assign key_rise = stable[N_KEY-1:0] & ~stable_d[N_KEY-1:0];
  assign sw_diff  = stable[NI-1:N_KEY] ^ stable_d[NI-1:N_KEY];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_press <= '0;
      sw_change <= '0;
    end else begin
      key_press <= key_rise;
      sw_change <= sw_diff;
    end
  end

`ifdef INPUT_COND_RELEASE_EN
  logic [N_KEY-1:0] key_fall;

  assign key_fall = ~stable[N_KEY-1:0] & stable_d[N_KEY-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) key_release <= '0;
    else          key_release <= key_fall;
  end
`else
  assign key_release = '0;
`endif

  // Event word is fed by the registered pulses, so an ack in a pulse cycle keeps that pulse.
  logic [15:0] pulse_vec;

  always_comb begin
    pulse_vec                = '0;
    pulse_vec[0 +: N_KEY]    = key_press;
    pulse_vec[2 +: N_KEY]    = key_release;
    pulse_vec[4 +: N_SW]     = sw_change;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       event_word <= '0;
    else if (event_ack) event_word <= pulse_vec;
    else                event_word <= event_word | pulse_vec;
  end

  assign event_valid = |event_word;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected edge events are queued at stimulus time and compared when pulses appear.
// Inputs are driven on the falling edge, so a held raw change produces its pulse exactly DEBOUNCE_CYCLES+3 cycles later.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int NK  = 2;
  localparam int NS  = 10;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key_raw;
  logic [NS-1:0] sw_raw;
  logic [NK-1:0] key_level;
  logic [NS-1:0] sw_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NS-1:0] sw_change;
  logic [15:0]   event_word;
  logic          event_valid;
  logic          event_ack;

  always #5 clock = ~clock;

  input_conditioner #(
    .N_KEY(NK), .N_SW(NS), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .key_raw(key_raw), .sw_raw(sw_raw),
    .key_level(key_level), .sw_level(sw_level),
    .key_press(key_press), .key_release(key_release), .sw_change(sw_change),
    .event_word(event_word), .event_valid(event_valid), .event_ack(event_ack)
  );

  typedef struct {
    string           name;
    logic [NK-1:0]   press;
    logic [NK-1:0]   rel;
    logic [NS-1:0]   change;
    logic [15:0]     word;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic tick;
    @(negedge clock);
  endtask

  function automatic bit any_pulse();
    return ((key_press | key_release) != '0) || (sw_change != '0);
  endfunction

  task automatic expect_event(input string name, input logic [NK-1:0] p, input logic [NK-1:0] r,
                              input logic [NS-1:0] c, input logic [15:0] w);
    exp_t e;
    e.name = name; e.press = p; e.rel = r; e.change = c; e.word = w;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation, waits (bounded) for the next pulse and checks it; optionally acks in the pulse cycle.
  task automatic wait_event(input bit ack_on_pulse);
    exp_t e;
    int   lat;
    bit   seen;
    if (sb.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e    = sb.pop_front();
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 4 * LAT) begin
      tick;
      lat++;
      seen = any_pulse();
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s timeout: no pulse within %0d cycles", e.name, 4 * LAT);
      return;
    end
    compared++;
    if (lat !== LAT) begin
      mismatched++;
      $display("FAIL %s latency: got %0d cycles, want %0d", e.name, lat, LAT);
    end
    compared++;
    if (key_press !== e.press) begin
      mismatched++;
      $display("FAIL %s key_press: got %b want %b", e.name, key_press, e.press);
    end
    compared++;
    if (key_release !== e.rel) begin
      mismatched++;
      $display("FAIL %s key_release: got %b want %b", e.name, key_release, e.rel);
    end
    compared++;
    if (sw_change !== e.change) begin
      mismatched++;
      $display("FAIL %s sw_change: got %h want %h", e.name, sw_change, e.change);
    end
    if (ack_on_pulse) event_ack = 1'b1;
    tick;
    event_ack = 1'b0;
    compared++;
    if (any_pulse()) begin
      mismatched++;
      $display("FAIL %s pulse_width: pulses still high one cycle later (%b %b %h)",
               e.name, key_press, key_release, sw_change);
    end
    compared++;
    if (event_word !== e.word) begin
      mismatched++;
      $display("FAIL %s event_word: got %h want %h", e.name, event_word, e.word);
    end
    compared++;
    if (event_valid !== (e.word != 16'h0)) begin
      mismatched++;
      $display("FAIL %s event_valid: got %b want %b", e.name, event_valid, e.word != 16'h0);
    end
  endtask

  task automatic do_ack;
    event_ack = 1'b1;
    tick;
    event_ack = 1'b0;
    compared++;
    if (event_word !== 16'h0 || event_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_clear: got word %h valid %b want 0000 0", event_word, event_valid);
    end
  endtask

  task automatic test_reset;
    int bad;
    reset_n   = 1'b0;
    key_raw   = '1;
    sw_raw    = '0;
    event_ack = 1'b0;
    repeat (2) tick;
    reset_n = 1'b1;
    sw_raw  = 10'h001;
    repeat (LAT + 3) tick;
    compared++;
    if (event_word !== 16'h0010 || sw_level !== 10'h001) begin
      mismatched++;
      $display("FAIL reset_setup: got word %h sw_level %h want 0010 001", event_word, sw_level);
    end
    #2;
    sw_raw  = '0;
    key_raw = 2'b11;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({key_level, sw_level, key_press, key_release, sw_change} !== '0) begin
      mismatched++;
      $display("FAIL reset_async_levels: got %b want all 0",
               {key_level, sw_level, key_press, key_release, sw_change});
    end
    compared++;
    if (event_word !== 16'h0 || event_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async_event: got word %h valid %b want 0000 0", event_word, event_valid);
    end
    tick;
    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      tick;
      if (any_pulse() || event_word != 16'h0) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL reset_quiet: got %0d cycles with activity want 0", bad);
    end
  endtask

  task automatic test_clean_press;
    key_raw[0] = 1'b0;
    expect_event("press0", 2'b01, 2'b00, '0, 16'h0001);
    wait_event(1'b0);
    compared++;
    if (key_level !== 2'b01) begin
      mismatched++;
      $display("FAIL press0_level: got %b want 01", key_level);
    end
  endtask

  task automatic test_release;
`ifdef INPUT_COND_RELEASE_EN
    key_raw[0] = 1'b1;
    expect_event("release0", 2'b00, 2'b01, '0, 16'h0005);
    wait_event(1'b0);
`else
    int bad;
    key_raw[0] = 1'b1;
    bad = 0;
    repeat (3 * LAT) begin
      tick;
      if (any_pulse()) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL release0_no_pulse: got %0d pulse cycles want 0", bad);
    end
    compared++;
    if (event_word !== 16'h0001) begin
      mismatched++;
      $display("FAIL release0_word: got %h want 0001", event_word);
    end
`endif
    compared++;
    if (key_level !== 2'b00) begin
      mismatched++;
      $display("FAIL release0_level: got %b want 00", key_level);
    end
  endtask

  task automatic test_bounce;
    int bad;
    do_ack();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      sw_raw[3] = ~sw_raw[3];
      repeat (2) begin
        tick;
        if (any_pulse()) bad++;
      end
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL bounce_quiet: got %0d pulse cycles while bouncing want 0", bad);
    end
    sw_raw[3] = 1'b1;
    expect_event("bounce_sw3", 2'b00, 2'b00, 10'h008, 16'h0080);
    wait_event(1'b0);
    compared++;
    if (sw_level !== 10'h008) begin
      mismatched++;
      $display("FAIL bounce_level: got %h want 008", sw_level);
    end
  endtask

  task automatic test_ack_collision;
    do_ack();
    sw_raw[0] = 1'b1;
    expect_event("sw0_set", 2'b00, 2'b00, 10'h001, 16'h0010);
    wait_event(1'b0);
    key_raw[1] = 1'b0;
    expect_event("ack_press1", 2'b10, 2'b00, '0, 16'h0002);
    wait_event(1'b1);
  endtask

  task automatic test_simultaneous;
    do_ack();
    sw_raw = '0;
    expect_event("sw_clear", 2'b00, 2'b00, 10'h009, 16'h0090);
    wait_event(1'b0);
    do_ack();
    sw_raw = '1;
    expect_event("sw_all", 2'b00, 2'b00, 10'h3FF, 16'h3FF0);
    wait_event(1'b0);
    compared++;
    if (sw_level !== 10'h3FF) begin
      mismatched++;
      $display("FAIL sw_all_level: got %h want 3ff", sw_level);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_ack_collision();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions the board's raw push-buttons and slide switches before they reach the CPU core's KEY/SW inputs. Each input is synchronised, debounced and edge-detected. Edge events are collected in a 16-bit sticky event word that the core reads and acknowledges. The block sits directly upstream of the ALU/CPU input ports and runs on the CPU clock.

## Interface
- `N_KEY`, default 2: number of push-buttons. Must be ≤ 2.
- `N_SW`, default 10: number of slide switches. Must be ≤ 10.
- `DEBOUNCE_CYCLES`, default 250000: cycles a synchronised input must hold a new value before it is accepted. Must be ≥ 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clock`  in  1: CPU clock. All state is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `key_raw`  in  N_KEY: raw buttons, active-low (0 = pressed), asynchronous.
- `sw_raw`  in  N_SW: raw switches, active-high, asynchronous.
- `key_level`  out  N_KEY: debounced button state, active-high (1 = pressed).
- `sw_level`  out  N_SW: debounced switch state.
- `key_press`  out  N_KEY: one-cycle pulse on a debounced press.
- `key_release`  out  N_KEY: one-cycle pulse on a debounced release.
- `sw_change`  out  N_SW: one-cycle pulse on any debounced switch change.
- `event_word`  out  16: sticky event flags.
- `event_valid`  out  1: equals `|event_word`.
- `event_ack`  in  1: clear request, sampled every cycle.

## Operation
- **Per-input pipeline:**
  - A 2-flop synchroniser feeds the comparator.
  - A stable register holds the accepted value.
  - A debounce counter measures how long the synchronised value has differed.
- **Buttons** are inverted before the synchroniser, so all internal logic is active-high.
- **Debounce counter:**
  - If synced == stable: counter clears to 0.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES-1` while synced != stable, stable takes the synced value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes stable.
- **Edge pulses** are registered from stable vs. its previous value. Each pulse is exactly 1 cycle wide and aligned with the cycle after stable changes.
- **event_word layout:**
  - [1:0] key press
  - [3:2] key release
  - [13:4] switch change
  - [15:14] always 0
  - Bits for unimplemented keys or switches (index ≥ N) are always 0.
- **Set/clear rule:**
  - A bit is set by its pulse.
  - When `event_ack`=1, the next `event_word` = pulses_this_cycle only. All previous bits clear and a simultaneous new event survives (set wins).
  - `event_ack` with `event_word`=0 has no effect.
- **Reset values:**
  - Key synchronisers and stable registers reset to "released" (0 internally).
  - Switch synchronisers and stable registers reset to 0.
  - All counters, pulses and `event_word` reset to 0.
  - The block does not suppress events after reset: a switch that is high at reset produces one `sw_change` event after debounce. The core is expected to ack once at boot.

## Timing
- **Accept latency:** a raw change held steady at cycle 0 reaches synced at the edge after cycle 2. stable updates `DEBOUNCE_CYCLES` cycles later, and the pulse/event bit follows 1 cycle after that. Total: `DEBOUNCE_CYCLES`+3 cycles ±1 for the asynchronous sampling.
- **Bounce:** a synced value that returns to stable at any count restarts measurement from 0 on the next change.
- **Simultaneous edges:** independent inputs changing in the same cycle produce pulses and event bits in the same cycle.
- **Reset mid-operation:** `reset_n` low clears all state immediately, with no clock needed. Partially counted debounces are discarded.
- **`event_ack` timing:** ack is level-sensitive. Holding it high for k cycles keeps `event_word` equal to the current-cycle pulses for those k cycles.

## Configuration
- `INPUT_COND_RELEASE_EN`:
  - **Defined:** `key_release` pulses are generated and `event_word[3:2]` latches releases.
  - **Undefined:** `key_release` is tied to 0, `event_word[3:2]` is always 0, and the release logic is not synthesised. `key_level` and `key_press` are unaffected.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, N_KEY=2, N_SW=10.
- **Reset:** `reset_n` low asynchronously mid-cycle with `key_raw`=2'b11, `sw_raw`=0 -> all outputs 0 immediately. After release, 20 cycles with no pulses.
- **Clean press:** `key_raw[0]` 1->0 and held -> `key_level[0]`=1 and a single `key_press[0]` pulse at 7±1 cycles. `event_word`=16'h0001 and `event_valid`=1.
- **Bounce:** `sw_raw[3]` toggles 0/1 every 2 cycles for 20 cycles, then holds 1 -> no `sw_change` during toggling. Exactly one pulse after the hold, then `event_word`=16'h0080.
- **Release (macro on):** after the press above, release `key_raw[0]` -> `key_release[0]` pulse and `event_word`=16'h0005. With the macro off -> no pulse and `event_word` stays 16'h0001.
- **Ack collision:** `event_word`=16'h0010, then `event_ack`=1 in the same cycle as the `key_press[1]` pulse -> next `event_word`=16'h0002.
- **Simultaneous:** `sw_raw` 0->10'h3FF in one cycle -> all 10 `sw_change` pulses in the same cycle and `event_word`=16'h3FF0.
